// File: rtl/wb_ahb_pkg.sv
// Bus encodings and bridge FSM states, shared by ahb2apb and wb2ahb.
package wb_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        ENABLE,
        RESP,
        ERR1,
        ERR2
    } state_e;

endpackage

// File: rtl/ahb2apb_if.sv
// AHB slave-side and APB master-side signals of the bridge.
interface ahb2apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [1:0]            htrans;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic                  hwrite;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [DATA_WIDTH-1:0] hwdata;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hready;
    logic [1:0]            hresp;

    logic [ADDR_WIDTH-1:0] paddr;
    logic [3:0]            psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    // The bridge itself: AHB slave, APB master.
    modport slave (
        input  hsel, htrans, hsize, hburst, hwrite, haddr, hwdata,
        output hrdata, hready, hresp,
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    // The surrounding system: AHB master and APB slaves.
    modport master (
        output hsel, htrans, hsize, hburst, hwrite, haddr, hwdata,
        input  hrdata, hready, hresp,
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/ahb2apb_dec.sv
// One-hot APB slave select from address bits [13:12].
module ahb2apb_dec (
    input  logic [1:0] addr_sel,
    output logic [3:0] psel_onehot
);
    always_comb begin
        psel_onehot = 4'b0001 << addr_sel;
    end
endmodule

// File: rtl/ahb2apb.sv
// Single-clock AHB-to-APB bridge: one APB access per accepted AHB transfer,
// bursts degrade to independent single transfers.
module ahb2apb
    import wb_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic     hclk,
    input  logic     hreset_n,
    ahb2apb_if.slave bus
);

    state_e                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,  paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    logic       accept;
    logic       hready;
    hresp_e     hresp;
    logic       psel_en;
    logic       penable;
    logic [3:0] psel_dec;

    // Size and burst type travel with the transfer but never change behaviour.
    logic unused_ok;
    assign unused_ok = ^{bus.hsize, bus.hburst};

    assign accept = bus.hsel
                  && (htrans_e'(bus.htrans) inside {HTRANS_NONSEQ, HTRANS_SEQ})
                  && (state_q inside {IDLE, RESP, ERR2});

    ahb2apb_dec u_dec (
        .addr_sel    (paddr_q[13:12]),
        .psel_onehot (psel_dec)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;
        hready   = 1'b1;
        hresp    = HRESP_OKAY;
        psel_en  = 1'b0;
        penable  = 1'b0;

        if (accept) begin
            paddr_d  = bus.haddr;
            pwrite_d = bus.hwrite;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = LATCH;
            end
            LATCH: begin
                hready = 1'b0;
                if (pwrite_q) pwdata_d = bus.hwdata;
                state_d = SETUP;
            end
            SETUP: begin
                hready  = 1'b0;
                psel_en = 1'b1;
                state_d = ENABLE;
            end
            ENABLE: begin
                hready  = 1'b0;
                psel_en = 1'b1;
                penable = 1'b1;
                if (bus.pready) begin
                    if (bus.pslverr) begin
                        state_d = ERR1;
                    end else begin
                        if (!pwrite_q) hrdata_d = bus.prdata;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = accept ? LATCH : IDLE;
            end
            ERR1: begin
                hready  = 1'b0;
                hresp   = HRESP_ERROR;
                state_d = ERR2;
            end
            ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = accept ? LATCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Handshake outputs decode straight from the state so reset clears them at once.
    assign bus.hready  = hready;
    assign bus.hresp   = hresp;
    assign bus.psel    = psel_en ? psel_dec : 4'b0000;
    assign bus.penable = penable;
    assign bus.paddr   = paddr_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.pwdata  = pwdata_q;
    assign bus.hrdata  = hrdata_q;

endmodule

// File: doc/ahb2apb.md
AHB2APB -- requirements
Module: ahb2apb

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AHB/APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, AHB/APB data width.
REQ-003 hclk  input  1  single clock for the AHB and APB sides.
REQ-004 hreset_n  input  1  reset, asynchronous, active-low.
REQ-005 hsel  input  1  bridge selected by the AHB decoder.
REQ-006 htrans  input  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 hsize  input  3  transfer size; carried only, never checked.
REQ-008 hburst  input  3  burst type; only SINGLE (000) is supported.
REQ-009 hwrite  input  1  1 = write.
REQ-010 haddr  input  ADDR_WIDTH  address-phase address.
REQ-011 hwdata  input  DATA_WIDTH  write data, valid in the first data-phase cycle.
REQ-012 hrdata  output  DATA_WIDTH  registered read data.
REQ-013 hready  output  1  transfer done / bridge ready.
REQ-014 hresp  output  2  00 OKAY, 01 ERROR.
REQ-015 paddr  output  ADDR_WIDTH  APB address.
REQ-016 psel  output  4  one-hot APB slave select.
REQ-017 penable  output  1  APB access phase.
REQ-018 pwrite  output  1  APB direction.
REQ-019 pwdata  output  DATA_WIDTH  APB write data.
REQ-020 prdata  input  DATA_WIDTH  APB read data, already muxed.
REQ-021 pready  input  1  APB slave ready.
REQ-022 pslverr  input  1  APB slave error, sampled with pready.

Function
REQ-023 The FSM SHALL use the states IDLE, LATCH, SETUP, ENABLE, RESP, ERR1 and ERR2.
REQ-024 Accept condition: hsel & htrans[1] & state in {IDLE, RESP, ERR2}; BUSY and IDLE transfers are ignored with an OKAY, zero-wait response.
REQ-025 On accept, haddr and hwrite SHALL be registered and the next state is LATCH.
REQ-026 LATCH: hready=0; register hwdata into pwdata (writes only); next state SETUP.
REQ-027 SETUP: psel[paddr[13:12]]=1, penable=0, hready=0; next state ENABLE.
REQ-028 ENABLE: psel held, penable=1, hready=0; remain in ENABLE while pready=0.
REQ-029 ENABLE with pready=1 and pslverr=0: hrdata<=prdata on reads (held otherwise); next state RESP.
REQ-030 ENABLE with pready=1 and pslverr=1: next state ERR1.
REQ-031 RESP: hready=1, hresp=OKAY, psel=0, penable=0; next state LATCH on accept, else IDLE.
REQ-032 ERR1: hready=0, hresp=ERROR; next state ERR2. ERR2: hready=1, hresp=ERROR; next state LATCH on accept, else IDLE.
REQ-033 IDLE: hready=1, hresp=OKAY, psel=0, penable=0.
REQ-034 paddr and pwrite SHALL stay stable from SETUP through the last ENABLE cycle.
REQ-035 Minimum data-phase latency SHALL be 4 cycles (3 with hready=0: LATCH, SETUP, ENABLE).
REQ-036 hsel=1 with hburst!=SINGLE SHALL be treated as a single transfer; SEQ is accepted like NONSEQ.

Reset
REQ-037 Asserting hreset_n=0, including mid-transfer, SHALL immediately force: state IDLE; hready=1; hresp=00; psel=0; penable=0; pwrite=0; paddr=0; pwdata=0; hrdata=0.
REQ-038 An APB access interrupted by reset SHALL NOT be resumed after reset is released.

Structure
REQ-039 A shared package wb_ahb_pkg SHALL hold the HTRANS/HRESP encodings and the FSM state enumeration; wb2ahb uses the same encodings.
REQ-040 A single sub-module, ahb2apb_dec, SHALL hold the combinational paddr[13:12] to one-hot psel decode.

Verification
REQ-041 Write 0x0000_2004 with data 0xDEADBEEF and pready=1 -> psel=0100 and pwdata=0xDEADBEEF in SETUP; hready low for 3 cycles; hresp=OKAY.
REQ-042 Read 0x0000_3000 with prdata=0x12345678 and pready low for 2 cycles -> ENABLE lasts 3 cycles and hrdata=0x12345678 when hready=1.
REQ-043 Read with pslverr=1 -> hresp=01 for 2 cycles, with hready 0 then 1.
REQ-044 Back-to-back NONSEQ accepted in RESP -> next state LATCH, no IDLE cycle, and paddr updates.
REQ-045 hreset_n driven low during ENABLE -> all outputs at reset values in the same cycle, and no APB access after release.
REQ-046 htrans=BUSY or IDLE with hsel=1 -> no psel activity, and hready stays 1.
